// File: rtl/conv_line_buf.sv
// conv_line_buf: three independent row FIFOs feeding the 3x3 window PE array.
// Every bank stores whole rows (LANES pixels of WIDTH bits). It returns one
// registered row per pop and reports occupancy and sticky error flags.
module conv_line_buf #(
  parameter int WIDTH = 9,
  parameter int LANES = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [LANES*WIDTH-1:0]   wr_data,
  input  logic [2:0]               mem_wr_en,
  input  logic [2:0]               mem_rd_en,
  output logic [LANES*WIDTH-1:0]   rd_data0,
  output logic [LANES*WIDTH-1:0]   rd_data1,
  output logic [LANES*WIDTH-1:0]   rd_data2,
  output logic [2:0]               rd_valid,
  output logic [2:0]               full,
  output logic [2:0]               empty,
  output logic [3*(AW+1)-1:0]      count,
  output logic [2:0]               err_ovf,
  output logic [2:0]               err_udf
);

  localparam int RW = LANES * WIDTH;
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [RW-1:0] w_rdData [3];

  for (genvar g = 0; g < 3; g++) begin : gBank
    logic [RW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic [RW-1:0] r_rdData;
    logic          r_rdValid;
    logic          r_errOvf;
    logic          r_errUdf;
    logic          w_full;
    logic          w_empty;
    logic          w_wrOk;
    logic          w_rdOk;

    assign w_full  = (r_count == FULLCNT);
    assign w_empty = (r_count == '0);

    // A full bank still takes a write when it is popped in the same cycle.
    // A pop needs data already present, so an empty bank never falls through.
    // clr masks both strobes.
    assign w_wrOk = mem_wr_en[g] && !clr && (!w_full || mem_rd_en[g]);
    assign w_rdOk = mem_rd_en[g] && !clr && !w_empty;

    // Row storage has no reset: contents survive clr and reset, and only written slots are read
    always_ff @(posedge clk) begin
      if (w_wrOk) r_mem[r_wrPtr] <= wr_data;
    end

    // Pointers, occupancy, read register and sticky error flags for this bank
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
        r_count   <= '0;
        r_rdData  <= '0;
        r_rdValid <= 1'b0;
        r_errOvf  <= 1'b0;
        r_errUdf  <= 1'b0;
      end else if (clr) begin
        r_wrPtr   <= '0;
        r_rdPtr   <= '0;
        r_count   <= '0;
        r_rdValid <= 1'b0;
        r_errOvf  <= 1'b0;
        r_errUdf  <= 1'b0;
      end else begin
        r_rdValid <= w_rdOk;
        if (w_wrOk) r_wrPtr <= r_wrPtr + AW'(1);
        if (w_rdOk) begin
          r_rdPtr  <= r_rdPtr + AW'(1);
          r_rdData <= r_mem[r_rdPtr];
        end
        case ({w_wrOk, w_rdOk})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
        if (mem_wr_en[g] && !w_wrOk) r_errOvf <= 1'b1;
        if (mem_rd_en[g] && w_empty) r_errUdf <= 1'b1;
      end
    end

    assign full[g]                    = w_full;
    assign empty[g]                   = w_empty;
    assign count[g*(AW+1) +: (AW+1)]  = r_count;
    assign rd_valid[g]                = r_rdValid;
    assign err_ovf[g]                 = r_errOvf;
    assign err_udf[g]                 = r_errUdf;
    assign w_rdData[g]                = r_rdData;
  end

  assign rd_data0 = w_rdData[0];
  assign rd_data1 = w_rdData[1];
  assign rd_data2 = w_rdData[2];

endmodule
